vector_alu: RTL
===============

Name: vector_alu

Overview:
Parametrised successor to the scalar 16-bit ALU in the Execute stage. The block is a LANES-wide SIMD ALU with per-lane NZCV flags and a per-lane enable mask. It uses a valid/ready handshake on both input and output, and adds an iterative multi-cycle multiply. It sits between Decode/Register-read and the Memory/Writeback stages of the vector pipeline.

Parameters:
N, 16, lane data width in bits (≥4, power of two).
LANES, 4, number of parallel lanes (≥1).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  operand bundle valid.
in_ready  out  1  block can accept the bundle this cycle.
in_op  in  4  opcode (see Behaviour).
in_mask  in  LANES  per-lane enable; bit i controls lane i.
in_a  in  LANES*N  operand A; lane i is [i*N +: N], two's complement.
in_b  in  LANES*N  operand B; same packing.
out_valid  out  1  result bundle valid.
out_ready  in  1  consumer accepts the result.
out_result  out  LANES*N  per-lane result, same packing.
out_flags  out  LANES*4  per-lane {N,Z,C,V}; bit3=N, bit2=Z, bit1=C, bit0=V.
out_err  out  1  the bundle carried an illegal opcode.
busy  out  1  state is not IDLE.

Behaviour:
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is b[$clog2(N)-1:0], and amount 0 returns a.
  - 1000 MUL: low N bits of the signed product.
  - 1001 MIN, 1010 MAX: signed.
  - 1011 ADDS, 1100 SUBS exist only with the optional feature.
  - All other codes are illegal.
- Flags, per lane:
  - N = result[N-1]; Z = (result == 0).
  - ADD: C = unsigned carry-out; V = signed overflow.
  - SUB: C = unsigned borrow (a < b unsigned); V = signed overflow.
  - MUL: C = 0; V = 1 if the full 2N-bit signed product does not fit in N signed bits.
  - Logic, shift, MIN, MAX: C = 0, V = 0.
- Masked-off lane: result = a, flags = 0000.
- Illegal opcode: all lane results and flags are 0, and out_err = 1.
- FSM states: IDLE, EXEC, DONE.
  - in_ready = (state == IDLE) || (state == DONE && out_ready).
  - Acceptance = in_valid && in_ready, sampled at a rising edge.
  - Non-MUL op: results are registered at the accepting edge and the state goes to DONE. out_valid is high the next cycle (latency 1, throughput 1 under continuous out_ready).
  - MUL: operands are loaded at the accepting edge and the state goes to EXEC with a step counter of 0. One shift-add step runs per cycle in all lanes in parallel. After N steps the state goes to DONE, so out_valid rises N cycles after acceptance.
  - DONE with out_ready and no new acceptance: go to IDLE and drop out_valid.
  - DONE with out_ready and a simultaneous acceptance: the output is replaced by the new bundle (or the state enters EXEC for MUL).
- While out_valid && !out_ready, out_result, out_flags and out_err hold stable.
- in_op, in_mask, in_a and in_b are sampled only at acceptance; changes during EXEC are ignored.
- Reset (including mid-MUL): state goes to IDLE immediately. out_valid, out_result, out_flags, out_err, busy and the step counter all clear to 0. The in-flight operation is discarded.

Optional Feature:
VECTOR_ALU_SAT_EN.
- Defined: 1011 ADDS and 1100 SUBS are signed saturating ops.
  - On overflow the result clamps to 2^(N-1)-1 or -2^(N-1), and V = 1 reports that saturation occurred.
  - C follows the ADD/SUB rules; N and Z come from the clamped result.
- Undefined: 1011 and 1100 are illegal opcodes (out_err = 1, zero results).

Decomposition:
- Package vector_alu_pkg:
  - alu_op_e enum for the opcodes.
  - Flag bit indices: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - fsm_state_e enum.
- Sub-module vector_alu_lane: combinational single-lane datapath for all non-MUL ops, plus the flag and saturation logic, instantiated LANES times via generate.
- The iterative multiplier registers and the FSM live in vector_alu.

Test Plan:
- ADD, lane0 a=4857 b=7465, mask=1111 -> result 12322, flags 0000; out_valid one cycle after acceptance.
- SUB, lane1 a=7465 b=4857 -> 2608, flags 0000. SUB, lane2 a=-5 b=2 -> -7, flags 1000. ADD, lane3 a=-5 b=2 -> -3, flags 1000.
- MUL, lane0 a=300 b=-7 -> -2100, flags 1000, out_valid exactly 16 cycles after acceptance. MUL a=300 b=300 -> 24464 (0x5F90), V=1. in_ready is 0 throughout EXEC.
- Back-pressure: hold out_ready=0 for 5 cycles after ADD a=32767 b=1 -> result -32768, flags 1001 held stable. Raise out_ready together with a new valid SUB bundle -> the SUB result appears the next cycle with no bubble.
- Mask and illegal op: mask=0101 with XOR -> lanes 1 and 3 return a with flags 0000. Op 1111 -> results 0, out_err=1.
- Reset during MUL step 7 -> out_valid=0 and busy=0 immediately. A fresh ADD 1+1 then completes -> 2, flags 0000. With VECTOR_ALU_SAT_EN, ADDS 32767+1 -> 32767, V=1.

Source files
------------

// File: rtl/vector_alu_pkg.sv
// vector_alu_pkg: opcodes, flag bit positions and FSM states shared by the vector ALU files.
package vector_alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLL  = 4'h5,
    OP_SRL  = 4'h6,
    OP_SRA  = 4'h7,
    OP_MUL  = 4'h8,
    OP_MIN  = 4'h9,
    OP_MAX  = 4'hA,
    OP_ADDS = 4'hB,
    OP_SUBS = 4'hC
  } alu_op_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} fsm_state_e;
endpackage

// File: rtl/vector_alu_lane.sv
// vector_alu_lane: combinational single-lane datapath with NZCV flags, lane mask and illegal-op detection.
// Ports: op (opcode), en (lane enable), a/b (operands), mul_p (full 2N-bit signed product for MUL),
//        res (lane result), flags ({N,Z,C,V}), err (opcode illegal).
// Optional: VECTOR_ALU_SAT_EN enables the saturating ADDS/SUBS opcodes.
module vector_alu_lane
  import vector_alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [3:0]     op,
  input  logic           en,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [2*N-1:0] mul_p,
  output logic [N-1:0]   res,
  output logic [3:0]     flags,
  output logic           err
);
  localparam int SW = $clog2(N);
  alu_op_e op_e;
  logic [N:0] sum, dif;
  logic [N-1:0] r;
  logic [SW-1:0] sh;
  logic add_v, sub_v, mul_v, c, v, ill;
  assign op_e = alu_op_e'(op);
  assign sh = b[SW-1:0];
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign add_v = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
  assign sub_v = (a[N-1] != b[N-1]) && (dif[N-1] != a[N-1]);
  // product fits in N signed bits only when its top N+1 bits are all equal
  assign mul_v = ~((&mul_p[2*N-1:N-1]) | ~(|mul_p[2*N-1:N-1]));
`ifdef VECTOR_ALU_SAT_EN
  logic [N-1:0] smax;
  assign smax = {1'b0, {(N-1){1'b1}}};
`endif
  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    ill = 1'b0;
    case (op_e)
      OP_ADD: begin r = sum[N-1:0]; c = sum[N]; v = add_v; end
      OP_SUB: begin r = dif[N-1:0]; c = dif[N]; v = sub_v; end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SLL: r = a << sh;
      OP_SRL: r = a >> sh;
      OP_SRA: r = $unsigned($signed(a) >>> sh);
      OP_MUL: begin r = mul_p[N-1:0]; v = mul_v; end
      OP_MIN: r = ($signed(a) < $signed(b)) ? a : b;
      OP_MAX: r = ($signed(a) < $signed(b)) ? b : a;
`ifdef VECTOR_ALU_SAT_EN
      // overflow sign follows operand a: positive overflow clamps to max, negative to min
      OP_ADDS: begin r = add_v ? (a[N-1] ? ~smax : smax) : sum[N-1:0]; c = sum[N]; v = add_v; end
      OP_SUBS: begin r = sub_v ? (a[N-1] ? ~smax : smax) : dif[N-1:0]; c = dif[N]; v = sub_v; end
`endif
      default: ill = 1'b1;
    endcase
  end
  assign err = ill;
  assign res = ill ? '0 : en ? r : a;
  assign flags = (ill || !en) ? 4'b0000 : {r[N-1], ~|r, c, v};
endmodule

// File: rtl/vector_alu.sv
// vector_alu: LANES-wide SIMD ALU with per-lane NZCV flags, lane mask, valid/ready handshake and iterative MUL.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_op/in_mask/in_a/in_b (operand bundle);
//        out_valid/out_ready/out_result/out_flags/out_err (result bundle); busy (state not IDLE).
// Optional: VECTOR_ALU_SAT_EN enables the saturating ADDS/SUBS opcodes.
module vector_alu
  import vector_alu_pkg::*;
#(
  parameter int N     = 16,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [LANES-1:0]   in_mask,
  input  logic [LANES*N-1:0] in_a,
  input  logic [LANES*N-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] out_result,
  output logic [LANES*4-1:0] out_flags,
  output logic               out_err,
  output logic               busy
);
  localparam int CW = $clog2(N);
  fsm_state_e state, state_n;
  logic [CW-1:0] cnt;
  logic [LANES-1:0] mask_q, lane_mask, err;
  logic [LANES*N-1:0] a_q, lane_a, res;
  logic [LANES*4-1:0] flg;
  logic [3:0] lane_op;
  logic accept, is_mul, exec, last;
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign is_mul = in_op == OP_MUL;
  assign exec = state == EXEC;
  assign last = exec && cnt == CW'(N - 1);
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  // lanes see live inputs at acceptance and the latched MUL operands while iterating
  assign lane_op = exec ? 4'(OP_MUL) : in_op;
  assign lane_mask = exec ? mask_q : in_mask;
  assign lane_a = exec ? a_q : in_a;
  always_comb begin
    state_n = accept ? (is_mul ? EXEC : DONE) :
              last ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      mask_q <= '0;
      a_q <= '0;
      out_result <= '0;
      out_flags <= '0;
      out_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= accept ? '0 : exec ? cnt + 1'b1 : cnt;
      if (accept) begin
        mask_q <= in_mask;
        a_q <= in_a;
      end
      if ((accept && !is_mul) || last) begin
        out_result <= res;
        out_flags <= flg;
        out_err <= |err;
      end
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [2*N-1:0] acc, mc, addend, acc_nx;
    logic [N-1:0] mp;
    assign addend = mp[0] ? mc : '0;
    // the multiplier's sign bit carries weight -2^(N-1), so the final step subtracts
    assign acc_nx = last ? acc - addend : acc + addend;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc <= '0;
        mc <= '0;
        mp <= '0;
      end else if (accept) begin
        acc <= '0;
        mc <= {{N{in_a[i*N+N-1]}}, in_a[i*N +: N]};
        mp <= in_b[i*N +: N];
      end else if (exec) begin
        acc <= acc_nx;
        mc <= mc << 1;
        mp <= mp >> 1;
      end
    end
    vector_alu_lane #(.N(N)) u_lane (
      .op    (lane_op),
      .en    (lane_mask[i]),
      .a     (lane_a[i*N +: N]),
      .b     (in_b[i*N +: N]),
      .mul_p (acc_nx),
      .res   (res[i*N +: N]),
      .flags (flg[i*4 +: 4]),
      .err   (err[i])
    );
  end
endmodule
